// File: rtl/shcnt_pkg.sv
// Shared definitions for the shift-sequence counter: mode encoding, seeds and
// maximal-length LFSR tap masks for widths 3..16.
// Optional feature macro: SHCNT_SELF_CORRECT_EN (illegal-state detection/correction).
package shcnt_pkg;

    typedef enum logic [1:0] {
        ModeRing    = 2'b00,
        ModeJohnson = 2'b01,
        ModeLfsr    = 2'b10,
        ModeHold    = 2'b11
    } shcnt_mode_e;

    // Seeds are stored at the maximum width and sliced down by the user.
    localparam logic [15:0] JOHNSON_SEED = 16'h0000;
    localparam logic [15:0] LFSR_SEED    = 16'h0001;

    // Feedback mask for a left-shifting Fibonacci LFSR: bit0_next = ^(state & mask).
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        logic [15:0] mask;
        case (width)
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0829;
            13:      mask = 16'h100D;
            14:      mask = 16'h2015;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/shcnt_next_state.sv
// Combinational step function of the shift-sequence counter. Computes the next
// state for the registered counting mode and, when SHCNT_SELF_CORRECT_EN is
// defined, flags states that do not belong to that mode's sequence.
module shcnt_next_state
    import shcnt_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] state,
    input  shcnt_mode_e      mode_q,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt
`ifdef SHCNT_SELF_CORRECT_EN
    ,
    output logic             illegal
`endif
);

    localparam logic [15:0] TAPS = lfsr_taps(WIDTH);

    logic [WIDTH-1:0] tap_mask;
    assign tap_mask = TAPS[WIDTH-1:0];

    // One step of the selected sequence; LFSR ignores dir.
    always_comb begin
        nxt = state;
        case (mode_q)
            ModeRing: begin
                nxt = dir ? {state[0], state[WIDTH-1:1]} : {state[WIDTH-2:0], state[WIDTH-1]};
            end
            ModeJohnson: begin
                nxt = dir ? {~state[0], state[WIDTH-1:1]} : {state[WIDTH-2:0], ~state[WIDTH-1]};
            end
            ModeLfsr: begin
                nxt = {state[WIDTH-2:0], ^(state & tap_mask)};
            end
            default: nxt = state;
        endcase
    end

`ifdef SHCNT_SELF_CORRECT_EN
    int unsigned ones;
    int unsigned edges;

    // Membership test: ring is one-hot, Johnson has at most one non-circular
    // bit transition, LFSR must never be all-zero (lock-up state).
    always_comb begin
        ones    = 0;
        edges   = 0;
        illegal = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + 32'(state[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            edges = edges + 32'(state[i] ^ state[i+1]);
        end
        case (mode_q)
            ModeRing:    illegal = (ones != 1);
            ModeJohnson: illegal = (edges > 1);
            ModeLfsr:    illegal = (state == '0);
            default:     illegal = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/shift_seq_counter.sv
// Shift-sequence counter: ring, Johnson or LFSR sequence with load, hold and
// direction control. Holds the state/mode registers, per-edge priority and the
// registered wrap/err pulses.
// Optional feature macro: SHCNT_SELF_CORRECT_EN (illegal-state correction, err pulse).
module shift_seq_counter
    import shcnt_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RING_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             err
);

    shcnt_mode_e      mode_in;
    shcnt_mode_e      mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_nxt;
    logic             mode_new;

    function automatic logic [WIDTH-1:0] seed_of(input shcnt_mode_e m);
        logic [WIDTH-1:0] s;
        case (m)
            ModeJohnson: s = JOHNSON_SEED[WIDTH-1:0];
            ModeLfsr:    s = LFSR_SEED[WIDTH-1:0];
            default:     s = RING_SEED;
        endcase
        return s;
    endfunction

    assign mode_in  = shcnt_mode_e'(mode);
    // Hold never becomes the registered mode, so it can never trigger a reload.
    assign mode_new = (mode_in != ModeHold) && (mode_in != mode_q);

`ifdef SHCNT_SELF_CORRECT_EN
    logic step_illegal;
    logic err_q, err_d;

    shcnt_next_state #(
        .WIDTH (WIDTH)
    ) u_next_state (
        .state   (out_q),
        .mode_q  (mode_q),
        .dir     (dir),
        .nxt     (step_nxt),
        .illegal (step_illegal)
    );
`else
    shcnt_next_state #(
        .WIDTH (WIDTH)
    ) u_next_state (
        .state  (out_q),
        .mode_q (mode_q),
        .dir    (dir),
        .nxt    (step_nxt)
    );
`endif

    // Per-edge priority: load > mode-change reload > hold > en step > keep.
    always_comb begin
        out_d  = out_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
`ifdef SHCNT_SELF_CORRECT_EN
        err_d  = 1'b0;
`endif
        if (load) begin
            out_d = load_val;
        end else if (mode_new) begin
            out_d  = seed_of(mode_in);
            mode_d = mode_in;
        end else if ((mode_in != ModeHold) && en) begin
`ifdef SHCNT_SELF_CORRECT_EN
            if (step_illegal) begin
                // Correction is not a count step, so it does not signal wrap.
                out_d = seed_of(mode_q);
                err_d = 1'b1;
            end else begin
                out_d  = step_nxt;
                wrap_d = (step_nxt == seed_of(mode_q));
            end
`else
            out_d  = step_nxt;
            wrap_d = (step_nxt == seed_of(mode_q));
`endif
        end
    end

    // State, mode and wrap registers with asynchronous reset to the ring seed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q  <= RING_SEED;
            mode_q <= ModeRing;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef SHCNT_SELF_CORRECT_EN
    // One-cycle error pulse on a corrected step.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out  = out_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_shift_seq_counter.sv
// Self-checking bench for shift_seq_counter (WIDTH=4): directed sequences from
// the requirements plus randomized stimulus against a behavioural model.
module tb_shift_seq_counter;

    localparam int unsigned W = 4;
    localparam int unsigned MASK = 32'hF;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         dir = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] out;
    logic         wrap;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_out;
    int unsigned m_mode;
    int unsigned m_wrap;
    int unsigned m_err;

    logic [3:0] exp_ring [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_john [9]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                  4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] exp_lfsr [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                                  4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                                  4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};

    shift_seq_counter #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned seed(input int unsigned m);
        return (m == 1) ? 0 : 1;
    endfunction

    // Sequence membership from the definition of each code.
    function automatic bit legal(input int unsigned v, input int unsigned m);
        int unsigned ones = 0;
        int unsigned trans = 0;
        for (int i = 0; i < W; i++) ones += (v >> i) & 1;
        for (int i = 0; i < W - 1; i++) trans += ((v >> i) ^ (v >> (i + 1))) & 1;
        if (m == 0) return ones == 1;
        if (m == 1) return trans <= 1;
        return v != 0;
    endfunction

    // Arithmetic form of the step rules; LFSR uses x^4 + x^3 + 1.
    function automatic int unsigned step(input int unsigned v, input int unsigned m,
                                         input bit d);
        int unsigned fb;
        if (m == 0) begin
            return d ? ((v >> 1) | ((v & 1) << (W - 1))) : (((v << 1) | (v >> (W - 1))) & MASK);
        end
        if (m == 1) begin
            return d ? ((v >> 1) | (((~v) & 1) << (W - 1)))
                     : (((v << 1) | (((~v) >> (W - 1)) & 1)) & MASK);
        end
        fb = ((v >> 3) ^ (v >> 2)) & 1;
        return ((v << 1) | fb) & MASK;
    endfunction

    task automatic model_reset();
        m_out  = 1;
        m_mode = 0;
        m_wrap = 0;
        m_err  = 0;
    endtask

    task automatic model_edge();
        int unsigned mi = 32'(mode);
        m_wrap = 0;
        m_err  = 0;
        if (load) begin
            m_out = 32'(load_val);
        end else if (mi != 3 && mi != m_mode) begin
            m_mode = mi;
            m_out  = seed(mi);
        end else if (mi != 3 && en) begin
`ifdef SHCNT_SELF_CORRECT_EN
            if (!legal(m_out, m_mode)) begin
                m_out = seed(m_mode);
                m_err = 1;
            end else
`endif
            begin
                m_out  = step(m_out, m_mode, dir);
                m_wrap = (m_out == seed(m_mode)) ? 1 : 0;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".out"}, 32'(out), m_out);
        check({tag, ".wrap"}, 32'(wrap), m_wrap);
        check({tag, ".err"}, 32'(err), m_err);
    endtask

    // One clock edge: update the model, sample 1ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    // Asynchronous reset pulse between edges; checks the immediate effect.
    task automatic async_reset(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        compare_model(tag);
        rstn = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset held across clock edges with active-looking inputs.
        en   = 1'b1;
        mode = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        compare_model("reset_hold");
        mode = 2'b00;
        rstn = 1'b1;

        // Ring, dir=0
        for (int i = 0; i < 4; i++) begin
            tick("ring");
            check("ring_seq", 32'(out), 32'(exp_ring[i]));
            check("ring_wrap", 32'(wrap), (i == 3) ? 1 : 0);
        end

        // Johnson: reload then full period
        mode = 2'b01;
        for (int i = 0; i < 9; i++) begin
            tick("john");
            check("john_seq", 32'(out), 32'(exp_john[i]));
            check("john_wrap", 32'(wrap), (i == 8) ? 1 : 0);
        end

        // LFSR: reload to seed, then 15 steps
        mode = 2'b10;
        tick("lfsr_reload");
        check("lfsr_seed", 32'(out), 32'h1);
        for (int i = 0; i < 15; i++) begin
            tick("lfsr");
            check("lfsr_seq", 32'(out), 32'(exp_lfsr[i]));
            check("lfsr_wrap", 32'(wrap), (i == 14) ? 1 : 0);
        end

        // Illegal ring load then step
        mode = 2'b00;
        tick("ring_reload");
        load     = 1'b1;
        load_val = 4'b0110;
        tick("load_bad");
        check("load_accept", 32'(out), 32'h6);
        load = 1'b0;
        tick("bad_step");
`ifdef SHCNT_SELF_CORRECT_EN
        check("bad_out", 32'(out), 32'h1);
        check("bad_err", 32'(err), 32'h1);
`else
        check("bad_out", 32'(out), 32'hC);
        check("bad_err", 32'(err), 32'h0);
`endif

        // Hold for three cycles, then resume without reload
        async_reset("rst_hold");
        tick("hold_pre");
        tick("hold_pre");
        check("hold_start", 32'(out), 32'h4);
        mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick("hold");
            check("hold_val", 32'(out), 32'h4);
        end
        mode = 2'b00;
        tick("hold_resume");
        check("hold_resume_val", 32'(out), 32'h8);

        // Async reset mid-Johnson, release with Johnson mode selected
        mode = 2'b01;
        for (int i = 0; i < 4; i++) tick("john_pre");
        check("john_at_0111", 32'(out), 32'h7);
        async_reset("rst_mid");
        check("rst_mid_out", 32'(out), 32'h1);
        tick("rst_release");
        check("rst_release_out", 32'(out), 32'h0);

        // Randomized stimulus against the model
        for (int n = 0; n < 800; n++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            load     = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
            tick("rnd");
            if ($urandom_range(0, 63) == 0) async_reset("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_counter.md
SHIFT_SEQ_COUNTER -- requirements
Module: shift_seq_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width; legal range 3..16.
REQ-002 The block SHALL have parameter RING_SEED, default 1, giving the one-hot ring start value.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: advance the sequence one step per cycle.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 ring, 01 Johnson, 10 LFSR, 11 hold.
REQ-007 The block SHALL have port dir, input, 1 bit: 0 shifts left (towards MSB), 1 shifts right; LFSR mode ignores it.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: the value loaded when load=1.
REQ-010 The block SHALL have port out, output, WIDTH bits: the registered counter state.
REQ-011 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a count step returns out to the active mode's seed.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse when an illegal state is corrected.

Function
REQ-013 All outputs SHALL be registered; out SHALL change only on a rising clk edge, except at reset.
REQ-014 Seeds SHALL be RING_SEED for ring, all-zeros for Johnson and 1 for LFSR.
REQ-015 Ring steps SHALL be: dir=0 gives out={out[W-2:0],out[W-1]}; dir=1 gives out={out[0],out[W-1:1]}; the period is WIDTH.
REQ-016 Johnson steps SHALL be: dir=0 gives out={out[W-2:0],~out[W-1]}; dir=1 gives out={~out[0],out[W-1:1]}; the period is 2*WIDTH.
REQ-017 LFSR mode SHALL be a Fibonacci LFSR shifting left with XOR feedback into bit0 from the package maximal-length tap table; the period is 2^WIDTH-1.
REQ-018 Hold mode (11) SHALL keep out unchanged regardless of en.
REQ-019 An internal register mode_q SHALL hold the last counting mode (00/01/10); selecting 11 SHALL NOT update mode_q.
REQ-020 Per-edge priority SHALL be, highest first: load (out<=load_val) > mode change (mode is 00/01/10 and differs from mode_q: out<=new seed, mode_q<=mode) > hold > en step > hold value.
REQ-021 A load or mode-change reload SHALL NOT raise wrap; wrap SHALL be asserted only for an en step whose result equals the seed of mode_q.
REQ-022 Illegal states SHALL be: ring, popcount(out)!=1; Johnson, more than one adjacent-bit transition in out[W-1:0] (non-circular); LFSR, out==0.
REQ-023 Load of an illegal value SHALL be accepted unchanged; handling applies at the next en step.
REQ-024 dir SHALL be sampled on every step; a change of dir mid-sequence SHALL reverse from the current state with no reload.

Reset
REQ-025 While rstn=0, out SHALL equal RING_SEED, mode_q SHALL equal ring, and wrap and err SHALL equal 0, independent of clk.
REQ-026 Reset mid-sequence SHALL abort immediately; on the first edge after release, a non-ring mode input SHALL trigger a mode-change reload.

Configuration
REQ-027 With SHCNT_SELF_CORRECT_EN defined, an en step from an illegal state SHALL produce out<=seed of mode_q and err=1 for one cycle.
REQ-028 Without SHCNT_SELF_CORRECT_EN, illegal states SHALL step by the normal rule, err SHALL be tied 0, and no detection logic SHALL be present.

Structure
REQ-029 Package shcnt_pkg SHALL hold the mode encoding enum, the LFSR tap-mask function or table for WIDTH 3..16, and the Johnson/LFSR seed constants.
REQ-030 Combinational sub-module shcnt_next_state SHALL compute the next state and the illegal flag from (state, mode_q, dir); the top holds the registers, priority and pulses.

Verification (WIDTH=4)
REQ-031 Ring, dir=0, en=1 after reset SHALL give out 0010, 0100, 1000, 0001, with wrap=1 on the 0001 cycle only.
REQ-032 Mode 01, en=1 SHALL give reload 0000, then 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, with wrap on the final 0000.
REQ-033 Mode 10 from seed SHALL give 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001, with wrap on 0001 (15 steps).
REQ-034 Ring, load=1 with load_val=0110, then en=1 SHALL give out=0001 and err=1 (macro on), or out=1100 and err=0 (macro off).
REQ-035 Ring at 0100, mode=11 for 3 cycles, then back to 00 SHALL hold 0100 with no reload, then step to 1000.
REQ-036 Asserting rstn=0 mid-clock during Johnson 0111 SHALL set out=0001 immediately; releasing with mode=01 SHALL reload 0000 on the next edge.
